// File: rtl/ecg_pkg.sv
// Shared definitions for the ECG apnea pipeline blocks.
//   rr_state_t : interval tracker state (ARM waits for a first peak,
//                MEASURE counts ticks since the last accepted peak)
//   FS_HZ      : nominal sample rate of the sample_en tick
//   MIN_RR_DEF : default refractory limit in ticks (250 ms @ 100 Hz)
//   MAX_RR_DEF : default timeout limit in ticks (2.5 s @ 100 Hz)
package ecg_pkg;

  typedef enum logic {
    ARM     = 1'b0,
    MEASURE = 1'b1
  } rr_state_t;

  localparam int unsigned FS_HZ      = 100;
  localparam int unsigned MIN_RR_DEF = 25;
  localparam int unsigned MAX_RR_DEF = 250;

endpackage

// File: rtl/rr_moving_avg.sv
// Moving average over the last 2^AVG_LOG2 pushed values.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : 1-cycle strobe, data is written into the circular buffer
//   flush      : discard history (fill and sum cleared, avg holds)
//   data       : value pushed
//   avg        : sum >> AVG_LOG2, updated the cycle after a push once full
//   avg_valid  : 1-cycle pulse, avg updated
//   avg_ready  : level, buffer full and avg meaningful
module rr_moving_avg #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             flush,
  input  logic [CNT_W-1:0] data,
  output logic [CNT_W-1:0] avg,
  output logic             avg_valid,
  output logic             avg_ready
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = CNT_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] DEPTH_F = (AVG_LOG2 + 1)'(DEPTH);

  logic [CNT_W-1:0]    buf_mem [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0]   fill;
  logic [SUM_W-1:0]    sum;

  logic                full;
  logic [CNT_W-1:0]    oldest;
  logic [SUM_W-1:0]    sum_next;
  logic [AVG_LOG2:0]   fill_next;

  always_comb begin
    full      = (fill == DEPTH_F);
    // Until the buffer has wrapped, the slot being overwritten holds no
    // history, so nothing is subtracted from the sum.
    oldest    = full ? buf_mem[wr_ptr] : '0;
    sum_next  = sum + SUM_W'(data) - SUM_W'(oldest);
    fill_next = full ? fill : fill + 1'b1;
  end

  assign avg_ready = full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      sum       <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (flush) begin
        wr_ptr <= '0;
        fill   <= '0;
        sum    <= '0;
      end else if (push) begin
        buf_mem[wr_ptr] <= data;
        wr_ptr          <= wr_ptr + 1'b1;
        sum             <= sum_next;
        fill            <= fill_next;
        if (fill_next == DEPTH_F) begin
          avg       <= CNT_W'(sum_next >> AVG_LOG2);
          avg_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_interval_tracker.sv
// R-R interval measurement between the R-peak detector and HRV stage.
//   clk, rst      : clock, asynchronous active-high reset
//   sample_en     : 1-cycle sample-rate tick; nothing advances without it
//   r_peak        : R-peak flag, qualified by sample_en
//   rr_value      : last accepted interval in ticks
//   rr_valid      : pulse, rr_value updated
//   rr_avg        : moving average of the last 2^AVG_LOG2 intervals
//   avg_valid     : pulse, rr_avg updated (one cycle after rr_valid)
//   avg_ready     : level, average buffer full
//   peak_rejected : pulse, peak inside refractory window ignored
//   rr_timeout    : pulse, no peak within MAX_RR ticks
module rr_interval_tracker
  import ecg_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MIN_RR   = MIN_RR_DEF,
  parameter int unsigned MAX_RR   = MAX_RR_DEF,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             r_peak,
  output logic [CNT_W-1:0] rr_value,
  output logic             rr_valid,
  output logic [CNT_W-1:0] rr_avg,
  output logic             avg_valid,
  output logic             avg_ready,
  output logic             peak_rejected,
  output logic             rr_timeout
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_RR);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_RR);

  rr_state_t        state;
  logic [CNT_W-1:0] count;
  logic             timeout_hit;

  // Decoded combinationally so the average history is dropped on the same
  // edge that raises rr_timeout, keeping avg_ready aligned with the pulse.
  assign timeout_hit = sample_en && (state == MEASURE) && !r_peak && (count == MAX_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ARM;
      count         <= '0;
      rr_value      <= '0;
      rr_valid      <= 1'b0;
      peak_rejected <= 1'b0;
      rr_timeout    <= 1'b0;
    end else begin
      rr_valid      <= 1'b0;
      peak_rejected <= 1'b0;
      rr_timeout    <= 1'b0;
      if (sample_en) begin
        case (state)
          ARM: begin
            if (r_peak) begin
              count <= CNT_W'(1);
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (r_peak) begin
              if (count < MIN_C) begin
                peak_rejected <= 1'b1;
                count         <= count + 1'b1;
              end else begin
                rr_value <= count;
                rr_valid <= 1'b1;
                count    <= CNT_W'(1);
              end
            end else if (count == MAX_C) begin
              rr_timeout <= 1'b1;
              count      <= '0;
              state      <= ARM;
            end else begin
              count <= count + 1'b1;
            end
          end
          default: state <= ARM;
        endcase
      end
    end
  end

  rr_moving_avg #(
    .CNT_W   (CNT_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk      (clk),
    .rst      (rst),
    .push     (rr_valid),
    .flush    (timeout_hit),
    .data     (rr_value),
    .avg      (rr_avg),
    .avg_valid(avg_valid),
    .avg_ready(avg_ready)
  );

endmodule

// File: tb/tb_rr_interval_tracker.sv
module tb_rr_interval_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_en = 1'b0;
  logic        r_peak = 1'b0;
  logic [15:0] rr_value;
  logic        rr_valid;
  logic [15:0] rr_avg;
  logic        avg_valid;
  logic        avg_ready;
  logic        peak_rejected;
  logic        rr_timeout;

  int checks = 0;
  int errors = 0;

  // Snapshots taken after each tick
  logic        s_valid, s_rej, s_to, s_avg_valid, s_ready;
  logic [15:0] s_value, s_avg;
  int          ev_valid, ev_rej, ev_to;

  always #5 clk = ~clk;

  rr_interval_tracker #(
    .CNT_W   (16),
    .MIN_RR  (25),
    .MAX_RR  (250),
    .AVG_LOG2(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .r_peak       (r_peak),
    .rr_value     (rr_value),
    .rr_valid     (rr_valid),
    .rr_avg       (rr_avg),
    .avg_valid    (avg_valid),
    .avg_ready    (avg_ready),
    .peak_rejected(peak_rejected),
    .rr_timeout   (rr_timeout)
  );

  // One sample tick spanning 4 clk cycles; sample_en high for the first.
  task automatic do_tick(input logic peak);
    @(negedge clk);
    sample_en = 1'b1;
    r_peak    = peak;
    @(negedge clk);
    sample_en = 1'b0;
    r_peak    = 1'b0;
    s_valid = rr_valid;
    s_value = rr_value;
    s_rej   = peak_rejected;
    s_to    = rr_timeout;
    @(negedge clk);
    s_avg_valid = avg_valid;
    s_avg       = rr_avg;
    s_ready     = avg_ready;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      do_tick(1'b0);
      if (s_valid) ev_valid++;
      if (s_rej)   ev_rej++;
      if (s_to)    ev_to++;
    end
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ev_valid = 0; ev_rej = 0; ev_to = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({rr_value, rr_valid, rr_avg, avg_valid, avg_ready, peak_rejected, rr_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got value=%0d avg=%0d flags=%b%b%b%b%b expected all 0",
               rr_value, rr_avg, rr_valid, avg_valid, avg_ready, peak_rejected, rr_timeout);
    end
    @(negedge clk);
    rst = 1'b0;
    ev_valid = 0; ev_rej = 0; ev_to = 0;
    do_tick(1'b1);
    checks++;
    if (s_valid !== 1'b0 || s_value !== 16'd0) begin
      errors++;
      $display("FAIL first_peak_arms: rr_valid=%b rr_value=%0d expected 0/0", s_valid, s_value);
    end
    idle(79);
    do_tick(1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_value !== 16'd80) begin
      errors++;
      $display("FAIL first_interval: rr_valid=%b rr_value=%0d expected 1/80", s_valid, s_value);
    end
  endtask

  task automatic test_reject;
    apply_reset;
    do_tick(1'b1);
    idle(79);
    do_tick(1'b1);
    idle(9);
    do_tick(1'b1);
    checks++;
    if (s_rej !== 1'b1 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL reject_tick90: peak_rejected=%b rr_valid=%b expected 1/0", s_rej, s_valid);
    end
    idle(69);
    do_tick(1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_value !== 16'd80 || s_rej !== 1'b0) begin
      errors++;
      $display("FAIL after_reject: rr_valid=%b rr_value=%0d rej=%b expected 1/80/0",
               s_valid, s_value, s_rej);
    end
  endtask

  task automatic test_average;
    apply_reset;
    do_tick(1'b1);
    for (int k = 1; k <= 4; k++) begin
      idle(79);
      do_tick(1'b1);
      if (k == 3) begin
        checks++;
        if (s_ready !== 1'b0 || s_avg_valid !== 1'b0) begin
          errors++;
          $display("FAIL avg_not_ready_3: avg_ready=%b avg_valid=%b expected 0/0", s_ready, s_avg_valid);
        end
      end
    end
    checks++;
    if (s_ready !== 1'b1 || s_avg_valid !== 1'b1 || s_avg !== 16'd80) begin
      errors++;
      $display("FAIL avg_full_80: ready=%b valid=%b rr_avg=%0d expected 1/1/80", s_ready, s_avg_valid, s_avg);
    end
    idle(99);
    do_tick(1'b1);
    checks++;
    if (s_value !== 16'd100 || s_avg_valid !== 1'b1 || s_avg !== 16'd85) begin
      errors++;
      $display("FAIL avg_85: rr_value=%0d valid=%b rr_avg=%0d expected 100/1/85", s_value, s_avg_valid, s_avg);
    end
    idle(100);
    do_tick(1'b1);
    checks++;
    if (s_value !== 16'd101 || s_avg !== 16'd90) begin
      errors++;
      $display("FAIL avg_90: rr_value=%0d rr_avg=%0d expected 101/90", s_value, s_avg);
    end
  endtask

  task automatic test_timeout;
    apply_reset;
    do_tick(1'b1);
    for (int k = 0; k < 4; k++) begin
      idle(79);
      do_tick(1'b1);
    end
    // last accepted peak is tick 0 of this scenario
    idle(249);
    checks++;
    if (ev_to !== 0) begin
      errors++;
      $display("FAIL early_timeout: timeouts=%0d expected 0", ev_to);
    end
    do_tick(1'b0);
    checks++;
    if (s_to !== 1'b1 || s_ready !== 1'b0 || s_value !== 16'd80 || s_avg !== 16'd80) begin
      errors++;
      $display("FAIL timeout_250: to=%b ready=%b rr_value=%0d rr_avg=%0d expected 1/0/80/80",
               s_to, s_ready, s_value, s_avg);
    end
    idle(9);
    do_tick(1'b1);
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL rearm_260: rr_valid=%b expected 0", s_valid);
    end
    idle(79);
    do_tick(1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_value !== 16'd80 || s_avg_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_rearm_340: rr_valid=%b rr_value=%0d avg_valid=%b expected 1/80/0",
               s_valid, s_value, s_avg_valid);
    end
  endtask

  task automatic test_boundary;
    apply_reset;
    do_tick(1'b1);
    idle(24);
    do_tick(1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_value !== 16'd25) begin
      errors++;
      $display("FAIL min_25: rr_valid=%b rr_value=%0d expected 1/25", s_valid, s_value);
    end
    idle(249);
    do_tick(1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_value !== 16'd250 || ev_to !== 0) begin
      errors++;
      $display("FAIL max_250: rr_valid=%b rr_value=%0d timeouts=%0d expected 1/250/0",
               s_valid, s_value, ev_to);
    end
    idle(23);
    do_tick(1'b1);
    checks++;
    if (s_rej !== 1'b1 || s_valid !== 1'b0 || s_value !== 16'd250) begin
      errors++;
      $display("FAIL reject_24: rej=%b rr_valid=%b rr_value=%0d expected 1/0/250", s_rej, s_valid, s_value);
    end
  endtask

  task automatic test_async_reset;
    apply_reset;
    do_tick(1'b1);
    idle(79);
    do_tick(1'b1);
    idle(49);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rr_value !== 16'd0 || rr_valid !== 1'b0 || avg_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rr_value=%0d rr_valid=%b avg_ready=%b expected 0/0/0",
               rr_value, rr_valid, avg_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    do_tick(1'b1);
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_peak: rr_valid=%b expected 0", s_valid);
    end
    idle(79);
    do_tick(1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_value !== 16'd80) begin
      errors++;
      $display("FAIL post_reset_interval: rr_valid=%b rr_value=%0d expected 1/80", s_valid, s_value);
    end
  endtask

  task automatic test_back_to_back;
    int nv, na;
    nv = 0; na = 0;
    apply_reset;
    for (int c = 0; c <= 103; c++) begin
      @(negedge clk);
      sample_en = (c <= 101);
      r_peak    = (c <= 100) && (c % 25 == 0);
      #1;
      if (rr_valid)  nv++;
      if (avg_valid) na++;
    end
    sample_en = 1'b0;
    r_peak    = 1'b0;
    checks++;
    if (nv !== 4 || na !== 1 || rr_avg !== 16'd25 || avg_ready !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: rr_valid=%0d avg_valid=%0d rr_avg=%0d ready=%b expected 4/1/25/1",
               nv, na, rr_avg, avg_ready);
    end
  endtask

  initial begin
    test_reset;
    test_reject;
    test_average;
    test_timeout;
    test_boundary;
    test_async_reset;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
